ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the decoded operation, operands and destination that ID emits (opcode, funct3, funct7, rs1/rs2 data, wreg_addr).
- Produces the wreg_en/wreg_addr/wreg_data triple that ID uses as its EX forwarding source.
- Holds the front end with a stall request while it iterates.

Parameters:
- XLEN, 32, operand/result width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  reset, synchronous, active-high.
- valid_i  in  1  ID presents a decoded instruction this cycle.
- opcode_i  in  7  opcode from ID.
- funct3_i  in  3  funct3 from ID.
- funct7_i  in  7  funct7 from ID.
- rs1_data_i  in  XLEN  forwarded rs1 value.
- rs2_data_i  in  XLEN  forwarded rs2 value.
- wreg_addr_i  in  ADDR_W  destination register.
- flush_i  in  1  pipeline flush; abort current operation.
- stall_req_o  out  1  hold IF/ID while unit is busy.
- wreg_en_o  out  1  one-cycle result-valid / register write enable.
- wreg_addr_o  out  ADDR_W  destination of result.
- wreg_data_o  out  XLEN  result.

Behaviour:
- Reset (nrst=1 at clock edge):
  - state=IDLE, counter=0.
  - wreg_en_o=0, wreg_addr_o=0, wreg_data_o=0.
  - stall_req_o=0.
  - Reset mid-operation discards the operation and produces no write.
- Start condition: state==IDLE && valid_i && opcode_i==7'b0110011 && funct7_i==7'b0000001 && !flush_i.
  - Other instructions are ignored; the unit stays IDLE.
- stall_req_o is combinational:
  - 1 in the start cycle.
  - 1 in every MUL/DIV state cycle.
  - 0 in IDLE without start, and 0 in DONE.
- On start, latch funct3, wreg_addr and operand magnitudes, plus sign flags:
  - funct3 0 (MUL): low 32 bits of the product.
  - funct3 1 (MULH): signed x signed, high 32 bits.
  - funct3 2 (MULHSU): signed x unsigned, high 32 bits.
  - funct3 3 (MULHU): unsigned x unsigned, high 32 bits.
  - funct3 4 (DIV): signed quotient.
  - funct3 5 (DIVU): unsigned quotient.
  - funct3 6 (REM): signed remainder.
  - funct3 7 (REMU): unsigned remainder.
  - Signed operands are converted to magnitude; unsigned are taken as-is.
- States:
  - IDLE -> MUL (funct3<4) or DIV (funct3>=4) on start, counter=XLEN-1.
  - MUL: one shift-add step per cycle into a 2*XLEN accumulator; counter decrements; at counter==0 go to DONE.
  - DIV: one restoring shift-subtract step per cycle (quotient and remainder registers); at counter==0 go to DONE.
  - DONE: for exactly one cycle, drive wreg_en_o=1 with wreg_addr_o and final wreg_data_o; next state IDLE.
    - A start is not accepted in DONE; it is accepted on the following IDLE cycle.
- Latency: start in cycle 0, XLEN compute cycles (1..32), wreg_en_o=1 in cycle 33.
- Sign correction in the final step:
  - Product is negated if the operand signs differ (signed variants only).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Divide special cases (fast path: IDLE -> DONE directly, wreg_en_o in cycle 1):
  - Divisor==0: quotient=all ones (0xFFFFFFFF), remainder=dividend.
  - Signed overflow 0x80000000 / -1: quotient=0x80000000, remainder=0.
- wreg_en_o=0 in all states except DONE.
- wreg_addr_o/wreg_data_o hold their last value outside DONE.
- flush_i=1 in any state: next state IDLE, no wreg_en_o pulse, stall_req_o=0 that cycle.
  - If flush_i coincides with DONE, the write still occurs; it is already committed.
- An x0 destination still produces a pulse; the register file discards it.

Optional Feature:
- Macro MULDIV_ZERO_EARLY_OUT_EN.
- Defined: at start, if a MUL-class operation has either operand ==0, or a DIV-class operation has dividend ==0 and divisor !=0, go IDLE -> DONE directly.
  - Result 0 for MUL-class, quotient 0 and remainder 0 for DIV-class; wreg_en_o in cycle 1.
- Undefined: these cases take the full 33-cycle path with identical results.
- Divide-by-zero and overflow fast paths exist in both builds.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), wreg_addr=5 -> stall_req_o high cycles 0-32; cycle 33 wreg_en_o=1, addr=5, data=0xFFFFFFEB.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> data=0xFFFFFFFE; MULH same operands -> data=0x00000000; MULHSU rs1=-1, rs2=2 -> data=0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each arrives in cycle 33.
- DIVU 5/0 -> cycle 1 data=0xFFFFFFFF; REM 5/0 -> data=5; DIV 0x80000000/0xFFFFFFFF -> cycle 1 data=0x80000000.
- Start MUL, assert flush_i in cycle 10 -> stall_req_o=0 that cycle, never any wreg_en_o; a new DIVU 9/3 started in cycle 12 returns 3 in cycle 45.
- Assert nrst in cycle 20 of a DIV -> all outputs 0 the next cycle, no write; with MULDIV_ZERO_EARLY_OUT_EN, MUL 0 x 123 -> wreg_en_o in cycle 1, data=0.

Source files
------------

// File: rtl/ex_muldiv.sv
`default_nettype none
// ==== ex_muldiv : iterative RV32M multiply/divide for EX (shift-add / restoring divide) ====
// ==== optional macro MULDIV_ZERO_EARLY_OUT_EN ; rev 1.0                                 ====
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [ADDR_W-1:0] wreg_addr_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              wreg_en_o,
  output logic [ADDR_W-1:0] wreg_addr_o,
  output logic [XLEN-1:0]   wreg_data_o
);

  localparam int         CNT_W     = $clog2(XLEN);
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op;
  logic [ADDR_W-1:0] dst;
  logic [XLEN-1:0]   b_mag;
  logic              neg_q;  // product sign for MUL-class, quotient sign for DIV-class
  logic              neg_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   quo, rem;

  logic              start, is_div_in;
  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, early;
  logic [XLEN-1:0]   fast_data;

  always_comb begin
    start     = (state == IDLE) && valid_i && (opcode_i == OP_RTYPE) &&
                (funct7_i == F7_MULDIV) && !flush_i;
    is_div_in = funct3_i[2];
    a_sgn     = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                (funct3_i == 3'd4) || (funct3_i == 3'd6);
    b_sgn     = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    a_neg     = a_sgn && rs1_data_i[XLEN-1];
    b_neg     = b_sgn && rs2_data_i[XLEN-1];
    a_abs     = a_neg ? -rs1_data_i : rs1_data_i;
    b_abs     = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero  = is_div_in && (rs2_data_i == '0);
    // signed DIV/REM only: most-negative / -1
    div_ovf   = is_div_in && !funct3_i[0] &&
                (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
`ifdef MULDIV_ZERO_EARLY_OUT_EN
    early     = (!is_div_in && ((rs1_data_i == '0) || (rs2_data_i == '0))) ||
                (is_div_in && (rs1_data_i == '0) && (rs2_data_i != '0));
`else
    early     = 1'b0;
`endif
    fast_data = '0;
    if (div_zero) begin
      fast_data = funct3_i[1] ? rs1_data_i : '1;
    end else if (div_ovf) begin
      fast_data = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_fix, r_fix, res;

  // One iteration step; the final result is formed from the step's output so
  // it can be registered on the same edge that enters DONE.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_nxt  = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = {rem, quo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_mag};
    if (rem_diff[XLEN]) begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = rem_diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end
    prod  = neg_q ? -acc_nxt : acc_nxt;
    q_fix = neg_q ? -quo_nxt : quo_nxt;
    r_fix = neg_r ? -rem_nxt : rem_nxt;
    if (state == DIV) begin
      res = op[1] ? r_fix : q_fix;
    end else begin
      res = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  logic              load_out;
  logic [XLEN-1:0]   out_data;
  logic [ADDR_W-1:0] out_addr;

  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    wreg_en_o   = 1'b0;
    load_out    = 1'b0;
    out_data    = res;
    out_addr    = dst;
    case (state)
      IDLE: begin
        if (start) begin
          stall_req_o = 1'b1;
          if (div_zero || div_ovf || early) begin
            state_nxt = DONE;
            load_out  = 1'b1;
            out_data  = fast_data;
            out_addr  = wreg_addr_i;
          end else begin
            state_nxt = is_div_in ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        stall_req_o = !flush_i;
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end
      end
      DONE: begin
        // already committed: a flush here does not cancel the write
        wreg_en_o = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      cnt         <= '0;
      op          <= '0;
      dst         <= '0;
      b_mag       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      quo         <= '0;
      rem         <= '0;
      wreg_addr_o <= '0;
      wreg_data_o <= '0;
    end else begin
      if (load_out) begin
        wreg_addr_o <= out_addr;
        wreg_data_o <= out_data;
      end
      if (start) begin
        cnt   <= CNT_W'(XLEN-1);
        op    <= funct3_i[1:0];
        dst   <= wreg_addr_i;
        b_mag <= b_abs;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        acc   <= {{XLEN{1'b0}}, a_abs};
        quo   <= a_abs;
        rem   <= '0;
      end else if (state == MUL) begin
        acc <= acc_nxt;
        cnt <= cnt - CNT_W'(1);
      end else if (state == DIV) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ==== tb_ex_muldiv : vector table + random ops vs. arithmetic model for ex_muldiv ====
// ==== rev 1.0                                                                     ====
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  waddr_in;
  logic        flush;
  logic        stall, wen;
  logic [4:0]  waddr_out;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .ADDR_W(5)) dut (
    .clk(clk), .nrst(nrst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .rs1_data_i(rs1), .rs2_data_i(rs2), .wreg_addr_i(waddr_in),
    .flush_i(flush), .stall_req_o(stall), .wreg_en_o(wen), .wreg_addr_o(waddr_out),
    .wreg_data_o(wdata)
  );

`ifdef MULDIV_ZERO_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  addr;
    logic [31:0] data;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: RV32M results straight from 64-bit / signed arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa32, sb32;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa32 = a; sb32 = b;
    sa = sa32; sb = sb32;
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    r = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa32 / sb32);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa32 % sb32);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_ZERO_EARLY_OUT_EN
    if (!f[2] && (a == 0 || b == 0)) return 1;
    if (f[2] && a == 0) return 1;
`endif
    return 33;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] ad);
    valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
    funct3 = f; rs1 = a; rs2 = b; waddr_in = ad;
  endtask

  // Start one op, wait for the write pulse, check timing/stall/result.
  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ad, input logic [31:0] exp, input int lat, input bit fd);
    int cyc; bit seen; bit busy_ok;
    @(negedge clk);
    drive(f, a, b, ad);
    #1 chk({nm, " stall_start"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (fd && cyc == lat) flush = 1'b1;
      #1;
      if (wen) seen = 1;
      else if (stall !== 1'b1) busy_ok = 0;
    end
    chk({nm, " stall_busy"}, 64'(busy_ok), 64'd1);
    chk({nm, " cycle"}, 64'(cyc), 64'(lat));
    chk({nm, " data"}, 64'(wdata), 64'(exp));
    chk({nm, " addr"}, 64'(waddr_out), 64'(ad));
    chk({nm, " done_stall"}, 64'(stall), 64'd0);
    flush = 1'b0;
  endtask

  initial begin
    vec_t vt[$];
    int c; bit bad;

    vt.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33});
    vt.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33});
    vt.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33});
    vt.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33});
    vt.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33});
    vt.push_back('{3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       33});
    vt.push_back('{3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        33});
    vt.push_back('{3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1});
    vt.push_back('{3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1});
    vt.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1});
    vt.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1});
    vt.push_back('{3'd0, 32'd0,        32'd123,      5'd0,  32'h00000000, EO_LAT});
    vt.push_back('{3'd3, 32'h00010000, 32'h00010000, 5'd17, 32'h00000001, 33});
    vt.push_back('{3'd4, 32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 33});
    vt.push_back('{3'd6, 32'd7,        32'hFFFFFFFE, 5'd19, 32'h00000001, 33});
    vt.push_back('{3'd5, 32'hFFFFFFFF, 32'd1,        5'd20, 32'hFFFFFFFF, 33});

    nrst = 1'b1; valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    rs1 = '0; rs2 = '0; waddr_in = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {wen, stall, waddr_out, wdata}, 64'd0);
    nrst = 1'b0;

    foreach (vt[i]) do_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].addr, vt[i].data, vt[i].lat, 1'b0);

    // Non-M instructions must be ignored.
    @(negedge clk);
    valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000000; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    #1 chk("ignore add stall", 64'(stall), 64'd0);
    @(negedge clk);
    opcode = 7'b0010011; funct7 = 7'b0000001;
    #1 chk("ignore opimm stall", 64'(stall), 64'd0);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("ignore no write", 64'(wen), 64'd0);

    // Start held through DONE is taken only on the following IDLE cycle.
    @(negedge clk);
    drive(3'd5, 32'd5, 32'd0, 5'd3);
    #1 chk("held start0 stall", 64'(stall), 64'd1);
    @(negedge clk);
    drive(3'd5, 32'd20, 32'd4, 5'd4);
    #1 chk("held done wen", 64'(wen), 64'd1);
    chk("held done stall", 64'(stall), 64'd0);
    @(negedge clk);
    #1 chk("held restart stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    c = 2;
    while (!wen && c < 60) begin
      @(negedge clk); c++; #1;
    end
    chk("held result cycle", 64'(c), 64'd35);
    chk("held result data", 64'(wdata), 64'd5);

    // Reset in the middle of a divide.
    @(negedge clk);
    drive(3'd4, 32'hFFFFFF9C, 32'd7, 5'd9);
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (19) @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1 chk("midreset outputs", {wen, stall, waddr_out, wdata}, 64'd0);
    nrst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (wen) bad = 1;
    end
    chk("midreset no write", 64'(bad), 64'd0);

    // Flush during MUL, then a fresh DIVU.
    @(negedge clk);
    drive(3'd0, 32'd3, 32'd5, 5'd3);
    @(posedge clk);
    #1 valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      flush = (k == 10);
      #1;
      if (wen) bad = 1;
      if (k == 10) chk("flush stall", 64'(stall), 64'd0);
      if (k == 11) chk("post-flush idle stall", 64'(stall), 64'd0);
    end
    @(negedge clk);
    drive(3'd5, 32'd9, 32'd3, 5'd21);
    #1 chk("flush restart stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    c = 12;
    while (!wen && c < 80) begin
      @(negedge clk); c++; #1;
    end
    chk("flush no stray write", 64'(bad), 64'd0);
    chk("flush divu cycle", 64'(c), 64'd45);
    chk("flush divu data", 64'(wdata), 64'd3);
    chk("flush divu addr", 64'(waddr_out), 64'd21);

    // Flush coinciding with DONE still writes.
    do_op("flush@done", 3'd7, 32'd50, 32'd8, 5'd22, 32'd2, 33, 1'b1);

    // Randomized ops against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ops[2];
      logic [2:0]  f;
      logic [4:0]  ad;
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 7))
          0: ops[j] = 32'h0;
          1: ops[j] = 32'hFFFFFFFF;
          2: ops[j] = 32'h80000000;
          3: ops[j] = 32'($urandom_range(0, 20));
          default: ops[j] = $urandom;
        endcase
      end
      f  = 3'($urandom_range(0, 7));
      ad = 5'($urandom_range(0, 31));
      do_op($sformatf("rnd%0d f%0d", n, f), f, ops[0], ops[1], ad, model(f, ops[0], ops[1]),
            exp_lat(f, ops[0], ops[1]), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
